// File: rtl/core_inst_seq.sv
// ============================================================================
// Module   : core_inst_seq
// Purpose  : Layer instruction sequencer for the 2D accelerator core. It fills
//            XMem from the host stream, then runs weight load, execute and
//            drain for each kij pass, issuing one 34-bit instruction per clock.
// Options  : SEQ_PERF_CNT_EN adds the cycle_count output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_inst_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int NACT_W = 8,
  parameter int NKIJ_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [NACT_W-1:0]   n_act,
  input  logic [NKIJ_W-1:0]   n_kij,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic [bw*row-1:0]   host_data,
  input  logic                core_valid,
  output logic [bw*row-1:0]   D_xmem,
  output logic [33:0]         inst,
  output logic                busy,
  output logic                done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_count
`endif
);

  localparam int c_CNT_W = 11;
  localparam int c_PH_W  = $clog2((1 << NACT_W) + row + col + 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FILL  = 3'd1;
  localparam logic [2:0] c_WLOAD = 3'd2;
  localparam logic [2:0] c_WPUSH = 3'd3;
  localparam logic [2:0] c_EXEC  = 3'd4;
  localparam logic [2:0] c_DRAIN = 3'd5;
  localparam logic [2:0] c_FIN   = 3'd6;

  localparam logic [33:0] c_RST_INST = 34'h1_800C_0000;

  logic [2:0]          r_state;
  logic [2:0]          w_nextState;
  logic                r_mode;
  logic [NACT_W-1:0]   r_nAct;
  logic [NKIJ_W-1:0]   r_nKij;
  logic [c_CNT_W-1:0]  r_fillCnt;
  logic [c_PH_W-1:0]   r_phaseCnt;
  logic [NACT_W-1:0]   r_drainCnt;
  logic [NKIJ_W-1:0]   r_kCnt;

  logic                w_startOk;
  logic                w_beat;
  logic [c_CNT_W-1:0]  w_fillTotal;
  logic [9:0]          w_wOff;
  logic [c_PH_W-1:0]   w_nActPh;
  logic [c_PH_W-1:0]   w_execLast;

  logic                w_acc;
  logic                w_pCen;
  logic                w_pWen;
  logic [10:0]         w_pAddr;
  logic                w_xCen;
  logic                w_xWen;
  logic [9:0]          w_xOff;
  logic                w_l0Rd;
  logic                w_l0Wr;
  logic                w_ofifoRd;
  logic                w_exec;
  logic                w_load;
  logic [bw*row-1:0]   w_dx;
  logic [33:0]         w_inst;

  assign w_startOk   = (r_state == c_IDLE) && start;
  assign w_beat      = (r_state == c_FILL) && host_valid && host_ready;
  assign w_fillTotal = c_CNT_W'(r_nAct) + c_CNT_W'(r_nKij) * c_CNT_W'(row);
  assign w_wOff      = 10'(r_nAct) + 10'(r_kCnt) * 10'(row) + 10'(r_phaseCnt);
  assign w_nActPh    = c_PH_W'(r_nAct);
  assign w_execLast  = w_nActPh + c_PH_W'(row + col);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_nextState = ((n_act == '0) || (n_kij == '0)) ? c_FIN : c_FILL;
        end
      end
      c_FILL: begin
        if (w_beat && (r_fillCnt == w_fillTotal - c_CNT_W'(1))) begin
          w_nextState = c_WLOAD;
        end
      end
      c_WLOAD: begin
        if (r_phaseCnt == c_PH_W'(row)) begin
          w_nextState = c_WPUSH;
        end
      end
      c_WPUSH: begin
        if (r_phaseCnt == c_PH_W'(row + col - 1)) begin
          w_nextState = c_EXEC;
        end
      end
      c_EXEC: begin
        if (r_phaseCnt == w_execLast) begin
          w_nextState = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (core_valid && (r_drainCnt == r_nAct - NACT_W'(1))) begin
          w_nextState = (r_kCnt == r_nKij - NKIJ_W'(1)) ? c_FIN : c_WLOAD;
        end
      end
      c_FIN:   w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Output decode for the current state; the result is registered below
  always_comb begin
    w_acc     = 1'b0;
    w_pCen    = 1'b1;
    w_pWen    = 1'b1;
    w_pAddr   = '0;
    w_xCen    = 1'b1;
    w_xWen    = 1'b1;
    w_xOff    = '0;
    w_l0Rd    = 1'b0;
    w_l0Wr    = 1'b0;
    w_ofifoRd = 1'b0;
    w_exec    = 1'b0;
    w_load    = 1'b0;
    w_dx      = '0;
    case (r_state)
      c_FILL: begin
        if (w_beat) begin
          w_xCen = 1'b0;
          w_xWen = 1'b0;
          w_xOff = r_fillCnt[9:0];
          w_dx   = host_data;
        end
      end
      c_WLOAD: begin
        if (r_phaseCnt < c_PH_W'(row)) begin
          w_xCen = 1'b0;
          w_xOff = w_wOff;
        end
        // SRAM read data lands one cycle later, so L0 writes trail reads by one
        w_l0Wr = (r_phaseCnt != '0);
      end
      c_WPUSH: begin
        w_l0Rd = 1'b1;
        w_load = 1'b1;
      end
      c_EXEC: begin
        if (r_phaseCnt < w_nActPh) begin
          w_xCen = 1'b0;
          w_xOff = 10'(r_phaseCnt);
        end
        w_l0Wr = (r_phaseCnt != '0) && (r_phaseCnt <= w_nActPh);
        w_l0Rd = (r_phaseCnt != '0);
        w_exec = (r_phaseCnt != '0);
      end
      c_DRAIN: begin
        if (core_valid) begin
          w_ofifoRd = 1'b1;
          w_pCen    = 1'b0;
          w_pWen    = 1'b0;
          w_pAddr   = 11'(r_drainCnt);
          w_acc     = (r_kCnt != '0);
        end
      end
      default: ;
    endcase
    w_inst = {w_acc, w_pCen, w_pWen, w_pAddr, w_xCen, w_xWen, w_xOff, r_mode,
              w_l0Rd, w_l0Wr, w_ofifoRd, 2'b00, w_exec, w_load};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= 1'b0;
      r_nAct     <= '0;
      r_nKij     <= '0;
      r_fillCnt  <= '0;
      r_phaseCnt <= '0;
      r_drainCnt <= '0;
      r_kCnt     <= '0;
    end else begin
      if (w_startOk) begin
        r_mode    <= mode;
        r_nAct    <= n_act;
        r_nKij    <= n_kij;
        r_fillCnt <= '0;
        r_kCnt    <= '0;
      end
      if (w_beat) begin
        r_fillCnt <= r_fillCnt + c_CNT_W'(1);
      end
      r_phaseCnt <= (w_nextState != r_state) ? '0 : r_phaseCnt + c_PH_W'(1);
      if ((r_state == c_DRAIN) && core_valid) begin
        r_drainCnt <= (w_nextState != c_DRAIN) ? '0 : r_drainCnt + NACT_W'(1);
      end
      if ((r_state == c_DRAIN) && (w_nextState == c_WLOAD)) begin
        r_kCnt <= r_kCnt + NKIJ_W'(1);
      end
    end
  end

  // host_ready tracks the upcoming state so a beat is only taken while in FILL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst       <= c_RST_INST;
      D_xmem     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_ready <= 1'b0;
    end else begin
      inst       <= w_inst;
      D_xmem     <= w_dx;
      busy       <= (r_state != c_IDLE);
      done       <= (r_state == c_FIN);
      host_ready <= (w_nextState == c_FILL);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_cycleCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycleCnt <= '0;
    end else if (w_startOk) begin
      r_cycleCnt <= '0;
    end else if (r_state != c_IDLE) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
    end
  end

  assign cycle_count = r_cycleCnt;
`endif

endmodule

`default_nettype wire

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Instruction initiator for the 2D accelerator core. Produces the 34-bit `inst` word and the `D_xmem` data that the core consumes.
- Sequences a full layer:
  - accepts activation and weight words from a host stream into XMem;
  - for each kernel position (kij), loads the weights, executes the activations, and drains the output FIFO into PSUM memory.
- Sits between the host/testbench stream and `core`. Emits exactly one instruction per clock.

Parameters:
- row, 8, PE array rows; also the number of weight words per kij.
- col, 8, PE array columns.
- bw, 4, activation/weight bit width.
- NACT_W, 8, width of the activation-count field.
- NKIJ_W, 4, width of the kij-count field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle launch pulse; sampled only in IDLE
- mode  in  1  0 = WS, 1 = OS; captured at start
- n_act  in  NACT_W  activations per pass; captured at start
- n_kij  in  NKIJ_W  number of kij passes; captured at start
- host_valid  in  1  host data beat valid
- host_ready  out  1  sequencer accepts a beat
- host_data  in  bw*row  host data word
- core_valid  in  1  core output FIFO has data
- D_xmem  out  bw*row  data bus to core XMem
- inst  out  34  instruction word to core
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse on leaving DRAIN of the last pass

Behaviour:
- Instruction fields:
  - [33] acc; [32] psum CEN; [31] psum WEN; [30:20] psum address.
  - [19] xmem CEN; [18] xmem WEN; [17:7] xmem address, of which [7] is also mode_select.
  - [6] l0_rd; [5] l0_wr; [4] ofifo_rd; [3:2] reserved (0); [1] execute; [0] load.
- XMem addressing:
  - Every XMem address is {offset[9:0], mode_r}, so inst[7] always equals the captured mode.
  - Activations occupy offset 0..n_act-1.
  - Weight r of pass k is at offset n_act + k*row + r.
- Idle word: CEN/WEN bits 1, all other bits 0, inst[7] = mode_r. Reset value of inst is 34'h1_800C_0000.
- Reset: all counters 0, mode_r 0, state IDLE, host_ready 0, busy 0, done 0, D_xmem 0. Reset is asynchronous and may assert at any time; the idle word appears immediately.
- State machine, one inst per cycle, registered outputs:
  - IDLE: start captures mode/n_act/n_kij.
    - If n_act==0 or n_kij==0, go to FIN.
    - Otherwise go to FILL.
  - FILL: host_ready=1.
    - Each beat with host_valid&host_ready issues an XMem write (CEN=0, WEN=0) at offset fill_cnt, with D_xmem=host_data, and increments fill_cnt.
    - No beat: idle word.
    - After n_act+n_kij*row beats, go to WLOAD with k=0.
  - WLOAD: row cycles of XMem reads (CEN=0, WEN=1) at the pass-k weight offsets.
    - l0_wr is asserted one cycle after each read (SRAM latency 1), so it overlaps the next read.
    - Go to WPUSH after the last l0_wr.
  - WPUSH: row+col cycles with l0_rd=1 and load=1, then go to EXEC.
  - EXEC: n_act XMem reads at offsets 0..n_act-1.
    - l0_wr follows each read by one cycle.
    - l0_rd=1 and execute=1 run from the first l0_wr cycle for n_act+row+col cycles.
    - Then go to DRAIN.
  - DRAIN: each cycle with core_valid=1 asserts ofifo_rd=1 and a PSUM write (CEN=0, WEN=0) at address drain_cnt, with acc=(k!=0).
    - core_valid=0 produces the idle word.
    - After n_act writes: if k==n_kij-1 go to FIN; otherwise k++ and go to WLOAD.
  - FIN: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Counters never wrap within a legal run. Legal runs satisfy n_act+n_kij*row ≤ 1024.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined:
  - adds output cycle_count[31:0];
  - cleared on accepted start and counts every busy cycle;
  - held after done until the next start;
  - reset to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-cycle → inst==34'h1_800C_0000 immediately, busy=0, host_ready=0; held through 3 clocks.
- start with mode=1, n_act=4, n_kij=1, host_valid toggling 1,0,1… for 12 beats → exactly 12 writes, at xmem addresses {0..11, 1} and D_xmem matching each beat; idle words in the gaps.
- Same run, core_valid held high → 8 WLOAD reads, 8 l0_wr, 16 WPUSH load cycles, 4 EXEC reads, 4 psum writes at addresses 0..3 with acc=0; done pulses once; busy falls the next cycle.
- n_kij=2, n_act=2 → second-pass weight reads at offsets 10..17; second-pass psum writes carry acc=1.
- start with n_act=0 → done two cycles after start, no XMem/PSUM access; start pulsed while busy → ignored, counts unchanged.
- Reset asserted during EXEC, then a new start with mode=0 → clean restart from FILL, inst[7]=0 throughout.
